// File: rtl/issue_select_if.sv
// Issue-select bus: allocation strobes and ready vector from the dependency
// matrix side, issue handshake with the FU, and free/clear feedback to the matrix.
interface issue_select_if #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 8
);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);

  logic                alloc_en;
  logic [ROW_W-1:0]    alloc_row_index;
  logic                alloc_has_dest;
  logic [COL_W-1:0]    alloc_col_index;
  logic [NUM_ROWS-1:0] ready_vector;
  logic                flush;
  logic                issue_valid;
  logic [ROW_W-1:0]    issue_row_index;
  logic                issue_ready;
  logic                free_en;
  logic [ROW_W-1:0]    free_row_index;
  logic                clear_en;
  logic [NUM_COLS-1:0] clear_lines;

  modport master (
    input  alloc_en, alloc_row_index, alloc_has_dest, alloc_col_index,
           ready_vector, flush, issue_ready,
    output issue_valid, issue_row_index, free_en, free_row_index,
           clear_en, clear_lines
  );

  modport slave (
    output alloc_en, alloc_row_index, alloc_has_dest, alloc_col_index,
           ready_vector, flush, issue_ready,
    input  issue_valid, issue_row_index, free_en, free_row_index,
           clear_en, clear_lines
  );
endinterface

// File: rtl/issue_select.sv
// Oldest-ready selection over the dependency matrix rows, a one-entry issue
// register towards the FU, and free/wake-up feedback when the FU accepts.
module issue_select #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 8
) (
  input  logic clk,
  input  logic rst,
  issue_select_if.master bus
);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);

  logic [NUM_ROWS-1:0] valid_q;
  logic [NUM_ROWS-1:0] picked_q;
  logic [NUM_ROWS-1:0] has_dest_q;
  logic [COL_W-1:0]    col_q   [NUM_ROWS];
  logic [NUM_ROWS-1:0] older_q [NUM_ROWS];
  logic                iss_valid_q;
  logic [ROW_W-1:0]    iss_row_q;

  logic [NUM_ROWS-1:0] cand;
  logic [NUM_ROWS-1:0] oldest;
  logic [ROW_W-1:0]    sel_row;
  logic                fire;
  logic                fire_fb;
  logic                load;

  assign cand    = bus.ready_vector & valid_q & ~picked_q;
  assign fire    = iss_valid_q && bus.issue_ready;
  // A flush or reset drops the held entry, so the matrix must not see a release.
  assign fire_fb = fire && !bus.flush && !rst;
  assign load    = (|cand) && (!iss_valid_q || fire);

  // A candidate is oldest when no other candidate was allocated before it.
  always_comb begin
    oldest = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      oldest[i] = cand[i];
      for (int j = 0; j < NUM_ROWS; j++) begin
        if (cand[j] && older_q[j][i]) oldest[i] = 1'b0;
      end
    end
  end

  // Valid rows carry a total age order, so at most one bit of oldest is set.
  always_comb begin
    sel_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (oldest[i]) sel_row = ROW_W'(i);
    end
  end

  assign bus.issue_valid     = iss_valid_q;
  assign bus.issue_row_index = iss_row_q;
  assign bus.free_en         = fire_fb;
  assign bus.free_row_index  = iss_row_q;
  assign bus.clear_en        = fire_fb && has_dest_q[iss_row_q];

  always_comb begin
    bus.clear_lines = '0;
    if (bus.clear_en) bus.clear_lines[col_q[iss_row_q]] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every update in
  // this block sees the pre-edge values of valid_q/picked_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      picked_q    <= '0;
      iss_valid_q <= 1'b0;
      iss_row_q   <= '0;
      for (int i = 0; i < NUM_ROWS; i++) older_q[i] <= '0;
    end else if (bus.flush) begin
      valid_q     <= '0;
      picked_q    <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      if (fire) begin
        valid_q[iss_row_q]  <= 1'b0;
        picked_q[iss_row_q] <= 1'b0;
      end
      if (bus.alloc_en) begin
        valid_q[bus.alloc_row_index]  <= 1'b1;
        picked_q[bus.alloc_row_index] <= 1'b0;
        older_q[bus.alloc_row_index]  <= '0;
        // Every live row becomes older than the new one; stale bits of dead rows are cleared.
        for (int j = 0; j < NUM_ROWS; j++) begin
          if (ROW_W'(j) != bus.alloc_row_index)
            older_q[j][bus.alloc_row_index] <= valid_q[j];
        end
      end
      if (load) begin
        iss_valid_q       <= 1'b1;
        iss_row_q         <= sel_row;
        picked_q[sel_row] <= 1'b1;
      end else if (fire) begin
        iss_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: payload storage is only read for valid rows, so it carries no reset.
  always_ff @(posedge clk) begin
    if (bus.alloc_en) begin
      has_dest_q[bus.alloc_row_index] <= bus.alloc_has_dest;
      col_q[bus.alloc_row_index]      <= bus.alloc_col_index;
    end
  end
endmodule
